// File: rtl/dbus_ctrl.sv
// Data-bus access controller for the memory stage: issues one bus transaction
// per load/store, stalls the pipeline until ack or timeout, and holds load data.
//
// state | meaning
// IDLE  | no transaction outstanding; a request is latched onto the bus
// BUSY  | bus_req_o high, waiting for ack or timeout on behalf of the stage
// HOLD  | transaction done, stage held by stall_i; present the held load word
// DRAIN | instruction flushed; keep the bus request alive until it completes
module dbus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] hold_data;

    logic ack;
    logic timeout;
    logic done;
    logic issue;

    // An ack only counts while our own request is on the bus.
    assign ack     = bus_req_o & bus_ack_i;
    assign timeout = bus_req_o & ~bus_ack_i & (cnt == TERM_CNT);
    assign done    = ack | timeout;
    assign issue   = (state == IDLE) & mem_ce_i & ~flush_i;

    always_comb begin
        stallreq_o = 1'b0;
        mem_data_o = 32'h0;
        bus_err_o  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: stallreq_o = issue;
                BUSY: begin
                    stallreq_o = ~done;
                    bus_err_o  = timeout;
                    if (ack) mem_data_o = bus_rdata_i;
                end
                HOLD: mem_data_o = hold_data;
                DRAIN: begin
                    stallreq_o = mem_ce_i;
                    bus_err_o  = timeout;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= 32'h0;
            hold_data   <= 32'h0;
            cnt         <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state       <= BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_data_i;
                        cnt         <= 8'h0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        bus_req_o <= 1'b0;
                        // A timed-out load completes with a zero word.
                        if (!bus_we_o) hold_data <= ack ? bus_rdata_i : 32'h0;
                        state <= (stall_i && !flush_i) ? HOLD : IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (flush_i) state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (flush_i || !stall_i) state <= IDLE;
                end
                DRAIN: begin
                    if (done) begin
                        bus_req_o <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Randomized scoreboard bench for dbus_ctrl: the stimulus queues each expected
// bus transaction, and a negedge monitor checks bus and pipeline-side outputs.
module tb_dbus_ctrl;

    localparam int TO      = 16;
    localparam int N_INSTR = 300;

    logic        clk;
    logic        rst;
    logic        mem_ce, mem_we, stall, flush, bus_ack;
    logic [31:0] mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_data, bus_addr, bus_wdata;
    logic        stallreq, bus_err, bus_req, bus_we;
    logic [3:0]  bus_sel;

    dbus_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce),
        .mem_we_i   (mem_we),
        .mem_addr_i (mem_addr),
        .mem_sel_i  (mem_sel),
        .mem_data_i (mem_wdata),
        .stall_i    (stall),
        .flush_i    (flush),
        .mem_data_o (mem_data),
        .stallreq_o (stallreq),
        .bus_err_o  (bus_err),
        .bus_req_o  (bus_req),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_sel_o  (bus_sel),
        .bus_wdata_o(bus_wdata),
        .bus_ack_i  (bus_ack),
        .bus_rdata_i(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    exp_t        cur;
    bit          cur_valid   = 0;
    int          req_cyc     = 0;
    bit          drained     = 0;
    bit          hold_act    = 0;
    bit          expect_drop = 0;
    bit          prev_req    = 0;
    bit          prev_rst    = 0;
    logic [31:0] hold_model  = 32'h0;
    logic [31:0] hold_exp    = 32'h0;

    always @(negedge clk) begin
        bit comp;
        comp = 0;
        if (prev_rst) begin
            check("reset_bus_req", 32'(bus_req), 32'h0);
            check("reset_bus_we", 32'(bus_we), 32'h0);
            check("reset_bus_addr", bus_addr, 32'h0);
            check("reset_bus_sel", 32'(bus_sel), 32'h0);
            check("reset_bus_wdata", bus_wdata, 32'h0);
        end
        if (rst) begin
            check("reset_stallreq", 32'(stallreq), 32'h0);
            check("reset_bus_err", 32'(bus_err), 32'h0);
            check("reset_mem_data", mem_data, 32'h0);
            cur_valid   = 0;
            drained     = 0;
            hold_act    = 0;
            hold_model  = 32'h0;
            expect_drop = 0;
            req_cyc     = 0;
        end else begin
            if (expect_drop) begin
                check("req_drop", 32'(bus_req), 32'h0);
                expect_drop = 0;
            end
            if (bus_req && !prev_req) begin
                check("req_expected", 32'(expq.size() != 0), 32'h1);
                if (expq.size() != 0) begin
                    cur       = expq.pop_front();
                    cur_valid = 1;
                    req_cyc   = 0;
                    drained   = 0;
                end
            end
            if (bus_req && cur_valid) begin
                req_cyc++;
                check("bus_we", 32'(bus_we), 32'(cur.we));
                check("bus_addr", bus_addr, cur.addr);
                check("bus_sel", 32'(bus_sel), 32'(cur.sel));
                check("bus_wdata", bus_wdata, cur.wdata);
                comp = bus_ack || (req_cyc == TO);
                check("bus_err", 32'(bus_err), 32'(comp && !bus_ack));
                check("busy_stallreq", 32'(stallreq), drained ? 32'(mem_ce) : 32'(!comp));
                if (drained)
                    check("drain_mem_data", mem_data, 32'h0);
                else if (comp)
                    check("done_mem_data", mem_data, bus_ack ? cur.rdata : 32'h0);
                if (comp) begin
                    expect_drop = 1;
                    cur_valid   = 0;
                    if (!drained && !cur.we) hold_model = bus_ack ? cur.rdata : 32'h0;
                    hold_act = !drained && stall;
                    hold_exp = hold_model;
                end else if (flush) begin
                    drained = 1;
                end
            end else if (hold_act) begin
                check("hold_stallreq", 32'(stallreq), 32'h0);
                check("hold_mem_data", mem_data, hold_exp);
                check("hold_bus_err", 32'(bus_err), 32'h0);
                if (!stall || flush) hold_act = 0;
            end else begin
                check("idle_stallreq", 32'(stallreq), 32'(mem_ce && !flush));
                check("idle_mem_data", mem_data, 32'h0);
                check("idle_bus_err", 32'(bus_err), 32'h0);
            end
        end
        prev_req = bus_req;
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    logic        i_we;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic [3:0]  i_sel;
    int          i_lat, i_stall_after, i_flush_at, i_gap;
    bit          i_hold_flush;
    bit          pre = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int n);
        int c;
        i_we          = 1'($urandom_range(0, 1));
        i_addr        = $urandom & 32'hFFFF_FFFC;
        i_sel         = 4'($urandom);
        i_wdata       = $urandom;
        i_rdata       = $urandom;
        i_lat         = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, TO + 3))
                                                    : int'($urandom_range(0, 3));
        i_stall_after = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
        i_hold_flush  = ($urandom_range(0, 3) == 0);
        i_gap         = int'($urandom_range(0, 2));
        i_flush_at    = -1;
        c = (i_lat >= TO) ? TO - 1 : i_lat;
        if (c >= 1 && $urandom_range(0, 3) == 0) i_flush_at = int'($urandom_range(0, c - 1));
        case (n)
            0: begin i_we = 0; i_addr = 32'h100; i_sel = 4'hF; i_rdata = 32'hDEADBEEF;
                     i_lat = 2; i_stall_after = 0; i_flush_at = -1; end
            1: begin i_we = 1; i_addr = 32'h204; i_sel = 4'b0011; i_wdata = 32'h1234ABCD;
                     i_lat = 0; i_stall_after = 0; i_flush_at = -1; end
            2: begin i_we = 0; i_addr = 32'h300; i_sel = 4'hF; i_rdata = 32'h55AA55AA;
                     i_lat = 0; i_stall_after = 4; i_hold_flush = 0; i_flush_at = -1; end
            3: begin i_we = 0; i_addr = 32'h400; i_sel = 4'hF;
                     i_lat = 20; i_stall_after = 0; i_flush_at = -1; end
            4: begin i_we = 0; i_addr = 32'h500; i_sel = 4'hF;
                     i_lat = 4; i_stall_after = 0; i_flush_at = 0; end
            default: ;
        endcase
    endtask

    task automatic drive_instr();
        mem_ce    = 1'b1;
        mem_we    = i_we;
        mem_addr  = i_addr;
        mem_sel   = i_sel;
        mem_wdata = i_wdata;
    endtask

    task automatic run_instr(input int n);
        int          comp, lat, fa, sa, gap;
        bit          hf;
        logic [31:0] rd;
        lat = i_lat; fa = i_flush_at; sa = i_stall_after; hf = i_hold_flush;
        rd = i_rdata; gap = i_gap;
        comp = (lat >= TO) ? TO - 1 : lat;
        drive_instr();
        flush   = 1'b0;
        stall   = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        expq.push_back('{we: i_we, addr: i_addr, sel: i_sel, wdata: i_wdata, rdata: rd});
        tick();
        for (int k = 0; k <= comp; k++) begin
            bus_ack   = (k == lat);
            bus_rdata = (k == lat) ? rd : $urandom;
            flush     = (k == fa);
            if (fa >= 0 && k == fa + 1) begin
                gen(n + 1);
                pre = 1;
                drive_instr();
            end
            stall = (k == comp) ? (fa < 0 && sa > 0) : 1'($urandom_range(0, 1));
            tick();
        end
        bus_ack = 1'b0;
        flush   = 1'b0;
        if (fa < 0 && sa > 0) begin
            for (int j = 1; j < sa; j++) begin
                stall   = 1'b1;
                bus_ack = 1'($urandom_range(0, 1));
                tick();
            end
            stall   = hf;
            flush   = hf;
            bus_ack = 1'($urandom_range(0, 1));
            tick();
            flush = 1'b0;
        end
        if (fa < 0) begin
            for (int g = 0; g < gap; g++) begin
                mem_ce    = 1'($urandom_range(0, 1));
                flush     = mem_ce;
                mem_addr  = $urandom;
                mem_we    = 1'($urandom_range(0, 1));
                stall     = 1'($urandom_range(0, 1));
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
                tick();
            end
            mem_ce  = 1'b0;
            flush   = 1'b0;
            bus_ack = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ce = 0; mem_we = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
        stall = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        for (int n = 0; n < N_INSTR; n++) begin
            if (!pre) gen(n);
            pre = 0;
            run_instr(n);
        end
        mem_ce = 1'b0; pre = 0;
        repeat (2) tick();

        // reset during the second BUSY cycle; a late ack must be ignored
        i_we = 0; i_addr = 32'h600; i_sel = 4'hF; i_wdata = 32'h0;
        drive_instr();
        expq.push_back('{we: 1'b0, addr: 32'h600, sel: 4'hF, wdata: 32'h0, rdata: 32'h0});
        tick();
        bus_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ce = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
        repeat (2) tick();
        bus_ack = 1'b0;
        tick();

        i_we = 0; i_addr = 32'h700; i_sel = 4'hC; i_rdata = 32'hCAFEF00D;
        i_lat = 1; i_stall_after = 0; i_flush_at = -1; i_gap = 0;
        run_instr(1000);
        repeat (3) tick();
        check("queue_empty", 32'(expq.size()), 32'h0);
        check("no_open_txn", 32'(cur_valid), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
